dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data-memory access port between the CPU memory stage (port 0) and an auxiliary bus master (port 1, loader/DMA). It sits directly in front of the data memory: it selects an owner, forwards its address/data/width/write-enable, and registers the read result back to that owner. Arbitration is round-robin with an optional bounded lock for multi-beat transfers. Port 1 is fenced out of the memory-mapped I/O region.

## Interface
- `MAX_HOLD`, 8: max consecutive locked grants to one port before forced release (≥1)
- `IO_BASE`, 32'hBFC01000: first I/O-mapped address; port-1 accesses at or above it are refused
- `clk` input 1: clock, all state on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `req0`/`req1` input 1: access request; held with fields stable until the matching `gnt`
- `lock0`/`lock1` input 1: keep ownership for the next access if still requesting
- `addr0`/`addr1` input 32: byte address
- `wdata0`/`wdata1` input 32: write data
- `wen0`/`wen1` input 1: 1 = store, 0 = load
- `width0`/`width1` input 3: access width code (000 W, 001 H, 010 B, 101 HU, 110 BU)
- `gnt0`/`gnt1` output 1: access performed this cycle
- `rvalid0`/`rvalid1` output 1: `rdata` valid for that port, one cycle after `gnt`
- `rdata` output 32: registered load data (shared; qualified by `rvalid`)
- `err1` output 1: with `rvalid1`, port-1 access was refused (I/O region)
- `mem_addr` output 32, `mem_wdata` output 32, `mem_wen` output 1, `mem_width` output 3: to data memory
- `mem_dout` input 32: combinational read data from data memory

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE: no memory port drive (`mem_wen`=0, `mem_addr`/`mem_wdata`=0, `mem_width`=000). Any `req` moves to OWNx next cycle; if both, pick the port pointed to by `rr_ptr`.
- OWNx: memory port is muxed from port x; `gnt_x`=1 combinationally. `mem_dout` is captured into `rdata` on the edge ending the cycle, and `rvalid_x`=1 in the following cycle. A store also asserts `rvalid_x` (so every grant gets exactly one response); `rdata` then holds the write data.
- Leaving OWNx at the end of a granted cycle:
  - if `lock_x` && `req_x` && `hold_cnt` < MAX_HOLD−1 → stay OWNx, increment `hold_cnt`;
  - else if `req_other` → OWNother, `hold_cnt`=0;
  - else if `req_x` → stay OWNx, `hold_cnt`=0;
  - else → IDLE.
- `rr_ptr` points to the non-owner after every grant.
- Forced release: on reaching MAX_HOLD, port x loses ownership only if the other port is requesting.
- Port-1 fence: in OWN1, if `addr1` ≥ IO_BASE, then `mem_wen` is forced 0 and `mem_addr` is forced 0. `gnt1` is still given. The response is `rvalid1`=1, `err1`=1, `rdata`=0. Port 0 is never fenced.
- A deasserted `req` in OWNx (protocol violation) yields no `gnt`. The FSM takes the release path.

## Timing
- Arbitration latency is 1 cycle: `req` at cycle N from IDLE → `gnt` at N+1 → `rvalid` at N+2.
- Back-to-back accesses by the same owner or alternating owners give one grant per cycle with no bubble.
- A store commits on the edge ending the `gnt` cycle.
- Reset values: state IDLE, `rr_ptr`=0 (port 0 preferred), `hold_cnt`=0, `gnt*`=0, `rvalid*`=0, `err1`=0, `rdata`=0, `mem_*`=0.
- Reset asserted during OWNx drops `mem_wen` immediately, so no store commits. No `rvalid` is produced after reset release.
- `hold_cnt` is sized to MAX_HOLD and saturates; it never wraps.

## Structure
- Shared package `dmem_pkg`:
  - width-code constants (`DW_WORD`, `DW_HALF`, `DW_BYTE`, `DW_HALFU`, `DW_BYTEU`), reused by the data memory and decoder;
  - `dmem_owner_t` enum {IDLE, OWN0, OWN1};
  - `IO_BASE` default.
- Sub-module `dmem_rr_pick`: combinational 2-way round-robin pick from (`req0`, `req1`, `rr_ptr`).
- Everything else lives in the top level.

## Test plan
- Single port-0 load: `req0`, `addr0`=0x10000, memory holds 0xDEADBEEF → `gnt0` at N+1, `rvalid0` and `rdata`=0xDEADBEEF at N+2.
- Simultaneous `req0`/`req1` from reset → grants alternate 0,1,0,1 with one grant per cycle.
- `lock1` held with `req0`, `req1` both high, MAX_HOLD=8 → 8 consecutive `gnt1`, then `gnt0`.
- Port-1 store to 0xBFC01004 → `mem_wen`=0, `gnt1`, then `rvalid1`+`err1`, `rdata`=0, memory unchanged. Same store on port 0 → `mem_wen`=1.
- Port-0 store 0x12345678, width 000, to 0x10010, then a port-1 load from it → `rdata`=0x12345678.
- `rst_n` pulsed low mid-OWN0 store → `mem_wen` drops asynchronously, memory is unchanged, and all outputs return to their reset values.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory path: access-width codes (also used by
// the data memory and the instruction decoder), the arbiter ownership type, the
// default start of the memory-mapped I/O region, and a region-check helper.
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Access width codes carried on width0/width1/mem_width
  localparam logic [2:0] DW_WORD  = 3'b000;
  localparam logic [2:0] DW_HALF  = 3'b001;
  localparam logic [2:0] DW_BYTE  = 3'b010;
  localparam logic [2:0] DW_HALFU = 3'b101;
  localparam logic [2:0] DW_BYTEU = 3'b110;

  // Default first I/O-mapped byte address
  localparam logic [31:0] IO_BASE_DFLT = 32'hBFC0_1000;

  // Current owner of the shared memory port
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } dmem_owner_t;

  // True when a byte address falls inside the I/O region starting at base
  function automatic logic in_io_region(input logic [31:0] addr,
                                        input logic [31:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
// Combinational two-way round-robin pick used when the arbiter is idle.
//   req0_i, req1_i : pending requests
//   rr_ptr_i       : preferred port when both request
//   valid_o        : at least one request pending
//   pick_o         : chosen port (0 or 1), meaningful only with valid_o
// -----------------------------------------------------------------------------
module dmem_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_ptr_i,
  output logic valid_o,
  output logic pick_o
);

  // Choose the pointed-to port on contention, otherwise the lone requester
  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      pick_o = rr_ptr_i;
    end else if (req1_i) begin
      pick_o = 1'b1;
    end else begin
      pick_o = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the CPU memory stage (port 0) and
// an auxiliary master (port 1). Round-robin with a bounded lock for multi-beat
// transfers; port 1 is fenced out of the I/O region.
//   clk, rst_n              : clock, async active-low reset
//   req/lock/addr/wdata/wen/width{0,1} : per-port request fields
//   gnt0, gnt1              : access performed this cycle (combinational)
//   rvalid0, rvalid1, rdata : registered response, one cycle after gnt
//   err1                    : with rvalid1, port-1 access refused (I/O region)
//   mem_addr/mem_wdata/mem_wen/mem_width : drive to data memory
//   mem_dout                : combinational read data from data memory
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter logic [31:0] IO_BASE  = IO_BASE_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        wen0,
  input  logic        wen1,
  input  logic [2:0]  width0,
  input  logic [2:0]  width1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [2:0]  mem_width,
  input  logic [31:0] mem_dout
);

  localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  dmem_owner_t       state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0] hold_inc_s;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              err1_q, err1_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              pick_valid_s, pick_s;
  logic              gnt0_s, gnt1_s, fence_s;

  dmem_rr_pick u_pick (
    .req0_i   (req0),
    .req1_i   (req1),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid_s),
    .pick_o   (pick_s)
  );

  // A grant needs both ownership and a live request; a dropped request in
  // OWNx is a protocol violation and must not touch memory.
  assign gnt0_s  = (state_q == OWN0) && req0;
  assign gnt1_s  = (state_q == OWN1) && req1;
  assign fence_s = (state_q == OWN1) && in_io_region(addr1, IO_BASE);

  // Saturating increment so the lock counter can never wrap
  assign hold_inc_s = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : (hold_cnt_q + HOLD_ONE);

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err1    = err1_q;
  assign rdata   = rdata_q;

  // Memory-port mux; idle drives all zeros, fenced port-1 accesses lose
  // address and write enable but keep their grant.
  always_comb begin
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_wen   = 1'b0;
    mem_width = 3'b000;
    case (state_q)
      OWN0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wen   = gnt0_s & wen0;
        mem_width = width0;
      end
      OWN1: begin
        if (fence_s) begin
          mem_addr = 32'h0000_0000;
        end else begin
          mem_addr = addr1;
        end
        mem_wdata = wdata1;
        mem_wen   = gnt1_s & wen1 & ~fence_s;
        mem_width = width1;
      end
      default: begin
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_wen   = 1'b0;
        mem_width = 3'b000;
      end
    endcase
  end

  // Ownership, round-robin pointer and lock counter next-state
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (pick_valid_s) begin
          state_d = pick_s ? OWN1 : OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (gnt0_s) begin
          rr_ptr_d = 1'b1;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
        if (lock0 && req0 && (hold_cnt_q < HOLD_LAST)) begin
          state_d    = OWN0;
          hold_cnt_d = hold_inc_s;
        end else if (req1) begin
          state_d    = OWN1;
          hold_cnt_d = '0;
        end else if (req0) begin
          state_d    = OWN0;
          hold_cnt_d = '0;
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      OWN1: begin
        if (gnt1_s) begin
          rr_ptr_d = 1'b0;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
        if (lock1 && req1 && (hold_cnt_q < HOLD_LAST)) begin
          state_d    = OWN1;
          hold_cnt_d = hold_inc_s;
        end else if (req0) begin
          state_d    = OWN0;
          hold_cnt_d = '0;
        end else if (req1) begin
          state_d    = OWN1;
          hold_cnt_d = '0;
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        rr_ptr_d   = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Response next-state: stores echo write data, fenced accesses return zero
  always_comb begin
    rvalid0_d = gnt0_s;
    rvalid1_d = gnt1_s;
    err1_d    = gnt1_s & fence_s;
    if (gnt0_s) begin
      rdata_d = wen0 ? wdata0 : mem_dout;
    end else if (gnt1_s) begin
      if (fence_s) begin
        rdata_d = 32'h0000_0000;
      end else if (wen1) begin
        rdata_d = wdata1;
      end else begin
        rdata_d = mem_dout;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      hold_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      err1_q     <= 1'b0;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      err1_q     <= err1_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small word-addressed data memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 time
// units after the edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        wen0, wen1;
  logic [2:0]  width0, width1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err1;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_wdata, mem_dout;
  logic        mem_wen;
  logic [2:0]  mem_width;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_HOLD(8), .IO_BASE(32'hBFC0_1000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .lock0     (lock0),
    .lock1     (lock1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wen0      (wen0),
    .wen1      (wen1),
    .width0    (width0),
    .width1    (width1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .err1      (err1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_width (mem_width),
    .mem_dout  (mem_dout)
  );

  // Data memory: combinational read, write on rising edge, bench preload port
  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_wen) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_gnt0"}, gnt0, 32'd0);
    chk({tag, "_gnt1"}, gnt1, 32'd0);
    chk({tag, "_rvalid0"}, rvalid0, 32'd0);
    chk({tag, "_rvalid1"}, rvalid1, 32'd0);
    chk({tag, "_err1"}, err1, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wen"}, mem_wen, 32'd0);
    chk({tag, "_mem_width"}, {29'd0, mem_width}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    wen0 = 1'b0; wen1 = 1'b0; width0 = 3'b000; width1 = 3'b000;
    pl_en = 1'b1; pl_idx = 8'd0; pl_data = 32'hDEAD_BEEF;

    // Preload: word 0 (0x10000) and word 1 (0x...004) under reset
    next_cycle();
    pl_idx = 8'd1; pl_data = 32'hA5A5_A5A5;
    next_cycle();
    pl_en = 1'b0;
    settle();
    chk_all_reset("reset");
    rst_n = 1'b1;

    // Single port-0 load from 0x10000
    next_cycle();
    req0 = 1'b1; addr0 = 32'h0001_0000; wen0 = 1'b0; width0 = 3'b000;
    settle();
    chk("ld0_n_gnt0", gnt0, 32'd0);
    next_cycle();
    settle();
    chk("ld0_n1_gnt0", gnt0, 32'd1);
    chk("ld0_n1_addr", mem_addr, 32'h0001_0000);
    chk("ld0_n1_rvalid0", rvalid0, 32'd0);
    next_cycle();
    req0 = 1'b0;
    settle();
    chk("ld0_n2_rvalid0", rvalid0, 32'd1);
    chk("ld0_n2_rdata", rdata, 32'hDEAD_BEEF);
    chk("ld0_n2_gnt0", gnt0, 32'd0);
    next_cycle();
    settle();
    chk("ld0_n3_rvalid0", rvalid0, 32'd0);

    // Both ports request from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    req0 = 1'b1; addr0 = 32'h0001_0000;
    req1 = 1'b1; addr1 = 32'h0001_0000; wen1 = 1'b0;
    settle();
    chk("rr_idle_gnt0", gnt0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      chk($sformatf("rr_%0d_gnt0", i), gnt0, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_%0d_gnt1", i), gnt1, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;
    settle();
    chk("rr_end_rvalid1", rvalid1, 32'd1);
    chk("rr_end_gnt0", gnt0, 32'd0);
    next_cycle();

    // Locked port 1 with both requesting: 8 grants to port 1, then port 0
    req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h0001_0000;
    next_cycle();
    req0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("lock_%0d_gnt1", i), gnt1, 32'd1);
      chk($sformatf("lock_%0d_gnt0", i), gnt0, 32'd0);
      next_cycle();
    end
    settle();
    chk("lock_rel_gnt0", gnt0, 32'd1);
    chk("lock_rel_gnt1", gnt1, 32'd0);
    chk("lock_rel_rdata", rdata, 32'hDEAD_BEEF);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    settle();
    chk("lock_end_rvalid0", rvalid0, 32'd1);
    next_cycle();

    // Port-1 store into the I/O region is fenced
    req1 = 1'b1; addr1 = 32'hBFC0_1004; wdata1 = 32'h55AA_55AA; wen1 = 1'b1;
    next_cycle();
    settle();
    chk("fence_gnt1", gnt1, 32'd1);
    chk("fence_mem_wen", mem_wen, 32'd0);
    chk("fence_mem_addr", mem_addr, 32'd0);
    next_cycle();
    req1 = 1'b0; wen1 = 1'b0;
    settle();
    chk("fence_rvalid1", rvalid1, 32'd1);
    chk("fence_err1", err1, 32'd1);
    chk("fence_rdata", rdata, 32'd0);
    chk("fence_mem_kept", mem[1], 32'hA5A5_A5A5);
    next_cycle();
    settle();
    chk("fence_err1_clr", err1, 32'd0);

    // Same store on port 0 is not fenced
    next_cycle();
    req0 = 1'b1; addr0 = 32'hBFC0_1004; wdata0 = 32'h55AA_55AA; wen0 = 1'b1;
    next_cycle();
    settle();
    chk("p0io_gnt0", gnt0, 32'd1);
    chk("p0io_mem_wen", mem_wen, 32'd1);
    chk("p0io_mem_addr", mem_addr, 32'hBFC0_1004);
    next_cycle();
    req0 = 1'b0; wen0 = 1'b0;
    settle();
    chk("p0io_rvalid0", rvalid0, 32'd1);
    chk("p0io_err1", err1, 32'd0);
    chk("p0io_rdata", rdata, 32'h55AA_55AA);
    chk("p0io_mem", mem[1], 32'h55AA_55AA);
    next_cycle();

    // Port-0 store then port-1 load of the same word, no bubble between
    req0 = 1'b1; addr0 = 32'h0001_0010; wdata0 = 32'h1234_5678; wen0 = 1'b1; width0 = 3'b000;
    next_cycle();
    req1 = 1'b1; addr1 = 32'h0001_0010; wen1 = 1'b0; width1 = 3'b000;
    settle();
    chk("st_gnt0", gnt0, 32'd1);
    chk("st_mem_wen", mem_wen, 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
    next_cycle();
    req0 = 1'b0; wen0 = 1'b0;
    settle();
    chk("ld1_gnt1", gnt1, 32'd1);
    chk("ld1_rvalid0", rvalid0, 32'd1);
    next_cycle();
    req1 = 1'b0;
    settle();
    chk("ld1_rvalid1", rvalid1, 32'd1);
    chk("ld1_rdata", rdata, 32'h1234_5678);
    chk("ld1_err1", err1, 32'd0);
    next_cycle();

    // Reset pulse during a port-0 store
    req0 = 1'b1; addr0 = 32'h0001_0000; wdata0 = 32'hCAFE_F00D; wen0 = 1'b1;
    next_cycle();
    settle();
    chk("rst_pre_mem_wen", mem_wen, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_wen", mem_wen, 32'd0);
    chk("rst_async_gnt0", gnt0, 32'd0);
    next_cycle();
    req0 = 1'b0; wen0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    settle();
    chk("rst_mem_kept", mem[0], 32'hDEAD_BEEF);
    chk_all_reset("rst_mid");
    rst_n = 1'b1;
    next_cycle();
    settle();
    chk("rst_rel_rvalid0", rvalid0, 32'd0);
    chk("rst_rel_rvalid1", rvalid1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
